// File: rtl/bicubic_wt_sched_if.sv
// Request, response and weight-pipeline signals of bicubic_wt_sched.
// slave = scheduler side, master = requesters / weight pipeline side.
interface bicubic_wt_sched_if #(
  parameter int WW = 17
);
  logic [8:0]      cfg_a;
  logic            cfg_upd;
  logic            h_req_vld;
  logic [8:0]      h_req_frac;
  logic            h_req_rdy;
  logic            v_req_vld;
  logic [8:0]      v_req_frac;
  logic            v_req_rdy;
  logic [8:0]      blend_out;
  logic            blend_vld;
  logic [8:0]      bi_a_out;
  logic [8:0]      coeff_one;
  logic [8:0]      coeff_half;
  logic [4*WW-1:0] wt_in;
  logic            h_rsp_vld;
  logic [4*WW-1:0] h_rsp_wt;
  logic            h_rsp_rdy;
  logic            v_rsp_vld;
  logic [4*WW-1:0] v_rsp_wt;
  logic            v_rsp_rdy;
  logic            busy;

  modport slave (
    input  cfg_a, cfg_upd, h_req_vld, h_req_frac, v_req_vld, v_req_frac,
           wt_in, h_rsp_rdy, v_rsp_rdy,
    output h_req_rdy, v_req_rdy, blend_out, blend_vld, bi_a_out, coeff_one,
           coeff_half, h_rsp_vld, h_rsp_wt, v_rsp_vld, v_rsp_wt, busy
  );

  modport master (
    output cfg_a, cfg_upd, h_req_vld, h_req_frac, v_req_vld, v_req_frac,
           wt_in, h_rsp_rdy, v_rsp_rdy,
    input  h_req_rdy, v_req_rdy, blend_out, blend_vld, bi_a_out, coeff_one,
           coeff_half, h_rsp_vld, h_rsp_wt, v_rsp_vld, v_rsp_wt, busy
  );
endinterface

// File: rtl/bicubic_wt_sched.sv
// Round-robin sharing of one fixed-latency bicubic weight pipeline between H and V
// phase generators, with credit-protected response FIFOs and a drained 'a' update.
//
// state | meaning
// RUN   | arbitration active
// DRAIN | cfg update pending, no grants until the pipeline is empty
// LOAD  | latched 'a' copied to bi_a_out, back to RUN next cycle
module bicubic_wt_sched #(
  parameter int PIPE_LAT   = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int WW         = 17,
  parameter int ONE        = 256
) (
  input logic               clk,
  input logic               rst_n,
  bicubic_wt_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 4 * WW;
  localparam logic [8:0]    FRAC_MAX = 9'(ONE - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t          state;
  logic            arb_en;
  logic            rr_v;
  logic [8:0]      a_lat;
  logic [8:0]      bi_a_r;
  logic [8:0]      blend_r;
  logic            blend_vld_r;
  logic [CW-1:0]   h_cnt, v_cnt, h_infl, v_infl;
  logic [AW-1:0]   h_wr, h_rd, v_wr, v_rd;
  logic [PIPE_LAT:0] dl_vld, dl_tag;
  logic [DW-1:0]   h_mem [FIFO_DEPTH];
  logic [DW-1:0]   v_mem [FIFO_DEPTH];

  logic            h_elig, v_elig, gnt_h, gnt_v;
  logic            arr_h, arr_v, pop_h, pop_v;
  logic [8:0]      h_frac_c, v_frac_c;

  assign h_frac_c = (bus.h_req_frac >= 9'(ONE)) ? FRAC_MAX : bus.h_req_frac;
  assign v_frac_c = (bus.v_req_frac >= 9'(ONE)) ? FRAC_MAX : bus.v_req_frac;

  // Credit = FIFO_DEPTH - occupancy - in-flight; grant only while positive.
  always_comb begin
    h_elig = bus.h_req_vld && arb_en && (state == RUN) && !bus.cfg_upd &&
             (({1'b0, h_cnt} + {1'b0, h_infl}) < DEPTH_C);
    v_elig = bus.v_req_vld && arb_en && (state == RUN) && !bus.cfg_upd &&
             (({1'b0, v_cnt} + {1'b0, v_infl}) < DEPTH_C);
    gnt_h  = h_elig && (!v_elig || !rr_v);
    gnt_v  = v_elig && (!h_elig || rr_v);
  end

  assign arr_h = dl_vld[PIPE_LAT] && !dl_tag[PIPE_LAT];
  assign arr_v = dl_vld[PIPE_LAT] &&  dl_tag[PIPE_LAT];
  assign pop_h = (h_cnt != '0) && bus.h_rsp_rdy;
  assign pop_v = (v_cnt != '0) && bus.v_rsp_rdy;

  assign bus.h_req_rdy  = gnt_h;
  assign bus.v_req_rdy  = gnt_v;
  assign bus.blend_out  = blend_r;
  assign bus.blend_vld  = blend_vld_r;
  assign bus.bi_a_out   = bi_a_r;
  assign bus.coeff_one  = 9'(ONE);
  assign bus.coeff_half = 9'(ONE / 2);
  assign bus.h_rsp_vld  = (h_cnt != '0);
  assign bus.v_rsp_vld  = (v_cnt != '0);
  assign bus.h_rsp_wt   = (h_cnt != '0) ? h_mem[h_rd] : '0;
  assign bus.v_rsp_wt   = (v_cnt != '0) ? v_mem[v_rd] : '0;
  assign bus.busy       = (state != RUN) || (h_infl != '0) || (v_infl != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en      <= 1'b0;
      rr_v        <= 1'b0;
      blend_r     <= '0;
      blend_vld_r <= 1'b0;
      dl_vld      <= '0;
      dl_tag      <= '0;
      h_infl      <= '0;
      v_infl      <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_wr        <= '0;
      h_rd        <= '0;
      v_wr        <= '0;
      v_rd        <= '0;
    end else begin
      arb_en      <= 1'b1;
      blend_vld_r <= gnt_h || gnt_v;
      if (gnt_h) begin
        blend_r <= h_frac_c;
        rr_v    <= 1'b1;
      end else if (gnt_v) begin
        blend_r <= v_frac_c;
        rr_v    <= 1'b0;
      end
      // Tag stage PIPE_LAT lines up with wt_in for the same issue.
      dl_vld <= {dl_vld[PIPE_LAT-1:0], gnt_h || gnt_v};
      dl_tag <= {dl_tag[PIPE_LAT-1:0], gnt_v};
      h_infl <= h_infl + CW'(gnt_h) - CW'(arr_h);
      v_infl <= v_infl + CW'(gnt_v) - CW'(arr_v);
      h_cnt  <= h_cnt + CW'(arr_h) - CW'(pop_h);
      v_cnt  <= v_cnt + CW'(arr_v) - CW'(pop_v);
      h_wr   <= h_wr + AW'(arr_h);
      v_wr   <= v_wr + AW'(arr_v);
      h_rd   <= h_rd + AW'(pop_h);
      v_rd   <= v_rd + AW'(pop_v);
    end
  end

  always_ff @(posedge clk) begin
    if (arr_h) h_mem[h_wr] <= bus.wt_in;
    if (arr_v) v_mem[v_wr] <= bus.wt_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      a_lat  <= '0;
      bi_a_r <= '0;
    end else begin
      if (bus.cfg_upd) a_lat <= bus.cfg_a;
      case (state)
        RUN:   if (bus.cfg_upd) state <= DRAIN;
        DRAIN: if ((h_infl == '0) && (v_infl == '0) && !blend_vld_r) state <= LOAD;
        LOAD: begin
          // A pulse landing in LOAD itself still wins.
          bi_a_r <= bus.cfg_upd ? bus.cfg_a : a_lat;
          state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_bicubic_wt_sched.sv
// Self-checking bench: transaction-level model of arbitration, credits, latency and 'a' update.
module tb_bicubic_wt_sched;
  localparam int PIPE_LAT = 6;
  localparam int DEPTH    = 8;
  localparam int WW       = 17;
  localparam int DW       = 4 * WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bicubic_wt_sched_if #(.WW(WW)) bus ();

  bicubic_wt_sched #(
    .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH), .WW(WW), .ONE(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] word;
    logic [8:0]    frac;
    int            rdy_cyc;
  } ent_t;

  ent_t          iss_q[$];
  ent_t          hq[$];
  ent_t          vq[$];
  logic [DW-1:0] wt_sched [int];

  int   passed = 0, fails = 0, total = 0;
  int   cyc = 0, g_last = -100, load_cyc = 0, hg_cnt = 0;
  logic rr_v = 1'b0, prev_gnt = 1'b0, in_drain = 1'b0, a_pend = 1'b0;
  logic [8:0] a_lat = '0, a_exp = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rf();
    return 9'($urandom_range(0, 300));
  endfunction

  function automatic logic [DW-1:0] rword();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check grants, advance model.
  task automatic step(input logic hv, input logic [8:0] hf, input logic vv, input logic [8:0] vf,
                      input logic hr, input logic vr, input logic upd, input logic [8:0] a);
    logic eh, ev, gh, gv, pop_h, pop_v, exp_hv, exp_vv, busy_exp;
    logic [8:0] f;
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (a_pend) begin
      a_exp  = a_lat;
      a_pend = 1'b0;
    end
    busy_exp = in_drain || (cyc > g_last && cyc <= g_last + PIPE_LAT + 1);
    chk("blend_vld", DW'(bus.blend_vld), DW'(prev_gnt));
    if (prev_gnt && iss_q.size() > 0) begin
      e = iss_q.pop_front();
      chk("blend_out", DW'(bus.blend_out), DW'(e.frac));
      wt_sched[cyc + PIPE_LAT] = e.word;
    end
    chk("bi_a_out", DW'(bus.bi_a_out), DW'(a_exp));
    chk("busy", DW'(bus.busy), DW'(busy_exp));
    exp_hv = (hq.size() > 0) && (hq[0].rdy_cyc <= cyc);
    exp_vv = (vq.size() > 0) && (vq[0].rdy_cyc <= cyc);
    chk("h_rsp_vld", DW'(bus.h_rsp_vld), DW'(exp_hv));
    chk("v_rsp_vld", DW'(bus.v_rsp_vld), DW'(exp_vv));
    if (exp_hv) chk("h_rsp_wt", bus.h_rsp_wt, hq[0].word);
    if (exp_vv) chk("v_rsp_wt", bus.v_rsp_wt, vq[0].word);
    pop_h = exp_hv && hr;
    pop_v = exp_vv && vr;

    bus.h_req_vld  = hv;
    bus.h_req_frac = hf;
    bus.v_req_vld  = vv;
    bus.v_req_frac = vf;
    bus.h_rsp_rdy  = hr;
    bus.v_rsp_rdy  = vr;
    bus.cfg_upd    = upd;
    bus.cfg_a      = a;
    bus.wt_in      = wt_sched.exists(cyc) ? wt_sched[cyc] : rword();
    if (upd) begin
      if (!in_drain) begin
        in_drain = 1'b1;
        load_cyc = ((cyc + 1 > g_last + PIPE_LAT + 2) ? cyc + 1 : g_last + PIPE_LAT + 2) + 1;
      end
      a_lat = a;
    end
    #1;
    eh = hv && (hq.size() < DEPTH) && !in_drain;
    ev = vv && (vq.size() < DEPTH) && !in_drain;
    gh = eh && (!ev || !rr_v);
    gv = ev && (!eh || rr_v);
    chk("h_req_rdy", DW'(bus.h_req_rdy), DW'(gh));
    chk("v_req_rdy", DW'(bus.v_req_rdy), DW'(gv));
    if (bus.h_req_rdy) hg_cnt++;
    if (gh || gv) begin
      rr_v      = gh;
      f         = gh ? hf : vf;
      e.word    = rword();
      e.frac    = (f >= 9'd256) ? 9'd255 : f;
      e.rdy_cyc = cyc + PIPE_LAT + 2;
      iss_q.push_back(e);
      if (gh) hq.push_back(e);
      else    vq.push_back(e);
      g_last = cyc;
    end
    prev_gnt = gh || gv;
    if (pop_h) void'(hq.pop_front());
    if (pop_v) void'(vq.pop_front());
    if (in_drain && cyc == load_cyc) begin
      in_drain = 1'b0;
      a_pend   = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_blend_vld"}, DW'(bus.blend_vld), '0);
    chk({pfx, "_blend_out"}, DW'(bus.blend_out), '0);
    chk({pfx, "_bi_a_out"},  DW'(bus.bi_a_out),  '0);
    chk({pfx, "_h_req_rdy"}, DW'(bus.h_req_rdy), '0);
    chk({pfx, "_v_req_rdy"}, DW'(bus.v_req_rdy), '0);
    chk({pfx, "_h_rsp_vld"}, DW'(bus.h_rsp_vld), '0);
    chk({pfx, "_v_rsp_vld"}, DW'(bus.v_rsp_vld), '0);
    chk({pfx, "_h_rsp_wt"},  bus.h_rsp_wt,       '0);
    chk({pfx, "_busy"},      DW'(bus.busy),      '0);
  endtask

  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #2;
    check_zero("rst_mid");
    iss_q.delete();
    hq.delete();
    vq.delete();
    rr_v     = 1'b0;
    prev_gnt = 1'b0;
    in_drain = 1'b0;
    a_pend   = 1'b0;
    a_lat    = '0;
    a_exp    = '0;
    g_last   = -100;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.cfg_a = '0;      bus.cfg_upd = 1'b0;
    bus.h_req_vld = 1'b1; bus.h_req_frac = 9'd5;
    bus.v_req_vld = 1'b1; bus.v_req_frac = 9'd6;
    bus.h_rsp_rdy = 1'b1; bus.v_rsp_rdy = 1'b1;
    bus.wt_in = '0;
    #2;
    check_zero("rst");
    chk("coeff_one",  DW'(bus.coeff_one),  DW'(256));
    chk("coeff_half", DW'(bus.coeff_half), DW'(128));
    @(negedge clk);
    bus.h_req_vld = 1'b0;
    bus.v_req_vld = 1'b0;
    rst_n = 1'b1;

    // Single H request, V idle.
    step(1, 9'd64, 0, 0, 1, 1, 0, 0);
    idle(10);

    // Both requesters continuously valid: strict alternation.
    hg_cnt = 0;
    for (int i = 0; i < 20; i++) step(1, rf(), 1, rf(), 1, 1, 0, 0);
    chk("alt_h_grants", DW'(hg_cnt), DW'(10));
    idle(12);

    // H responses not popped: credits cap H at FIFO_DEPTH grants, V keeps flowing.
    hg_cnt = 0;
    for (int i = 0; i < 30; i++) step(1, rf(), 1, rf(), 0, 1, 0, 0);
    chk("full_h_grants", DW'(hg_cnt), DW'(DEPTH));
    idle(20);

    // 'a' update with three issues in flight; second pulse during drain wins.
    step(1, 9'd10, 0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 9'd20, 1, 1, 0, 0);
    step(1, 9'd30, 0, 0, 1, 1, 0, 0);
    step(1, 9'd40, 1, 9'd50, 1, 1, 1, 9'd33);
    step(1, 9'd40, 1, 9'd50, 1, 1, 1, 9'd75);
    for (int i = 0; i < 14; i++) step(1, rf(), 1, rf(), 1, 1, 0, 0);
    chk("bi_a_after_cfg", DW'(bus.bi_a_out), DW'(75));
    idle(10);

    // Random traffic with back-pressure and occasional cfg updates.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rf(), $urandom_range(0, 2) != 0, rf(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, 9'($urandom_range(0, 511)));
    idle(20);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1, rf(), 1, rf(), 1, 1, 0, 0);
    reset_mid();
    step(1, 9'd100, 1, 9'd200, 1, 1, 0, 0);
    chk("first_gnt_after_rst", DW'(bus.h_req_rdy), DW'(1));
    idle(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
